// File: rtl/tank_motion_engine.sv
// tank_motion_engine: shared sequential per-frame tank mover with tile-map and tank-overlap checks
module tank_motion_engine #(
  parameter int N_TANKS = 2,
  parameter int MAP_W = 20,
  parameter int MAP_H = 15,
  parameter int TILE_LOG2 = 5,
  parameter int TANK_SIZE = 24,
  parameter int STEP = 2,
  parameter logic [20*N_TANKS-1:0] START_XY = {10'd576, 10'd416, 10'd32, 10'd32}
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_tick,
  input  logic [N_TANKS-1:0]              move_en,
  input  logic [2*N_TANKS-1:0]            move_dir,
  output logic [$clog2(MAP_W*MAP_H)-1:0]  map_addr,
  input  logic [2:0]                      map_data,
  output logic [10*N_TANKS-1:0]           tank_x,
  output logic [10*N_TANKS-1:0]           tank_y,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);
  localparam int AW = $clog2(MAP_W*MAP_H);
  localparam int IW = N_TANKS > 1 ? $clog2(N_TANKS) : 1;
  localparam logic [10:0] ST = 11'(STEP);
  localparam logic [10:0] SZ = 11'(TANK_SIZE);
  localparam logic [10:0] E = 11'(TANK_SIZE - 1);
  localparam logic [10:0] XMAX = 11'(MAP_W << TILE_LOG2);
  localparam logic [10:0] YMAX = 11'(MAP_H << TILE_LOG2);
  typedef enum logic [2:0] {IDLE, CALC, RDA, RDB, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [9:0] px [N_TANKS];
  logic [9:0] py [N_TANKS];
  logic [10:0] cx, cy, cx_r, cy_r, ax, ay, bx, by;
  logic [1:0] dir, dir_r;
  logic en_r, oor, oor_r, wall, hit, last, ok;
  function automatic logic [AW-1:0] tile(input logic [10:0] x, input logic [10:0] y);
    return AW'(32'(y >> TILE_LOG2) * MAP_W + 32'(x >> TILE_LOG2));
  endfunction
  function automatic logic near(input logic [10:0] a, input logic [10:0] b);
    return (a > b ? a - b : b - a) < SZ;
  endfunction
  always_comb begin
    dir = move_dir[{idx, 1'b0} +: 2];
    cx = {1'b0, px[idx]} + (dir == 2'd1 ? ST : '0) - (dir == 2'd3 ? ST : '0);
    cy = {1'b0, py[idx]} + (dir == 2'd2 ? ST : '0) - (dir == 2'd0 ? ST : '0);
    oor = dir == 2'd0 ? py[idx] < 10'(STEP) : dir == 2'd3 ? px[idx] < 10'(STEP) :
          dir == 2'd1 ? cx + SZ > XMAX : cy + SZ > YMAX;
    ax = cx + (dir == 2'd1 ? E : '0);
    ay = cy + (dir == 2'd2 ? E : '0);
    bx = cx_r + (dir_r == 2'd3 ? '0 : E);
    by = cy_r + (dir_r == 2'd0 ? '0 : E);
  end
  always_comb begin
    hit = 1'b0;
    for (int j = 0; j < N_TANKS; j++)
      hit = hit | (IW'(j) != idx && near(cx_r, {1'b0, px[j]}) && near(cy_r, {1'b0, py[j]}));
  end
  always_comb begin
    tank_x = '0;
    tank_y = '0;
    for (int i = 0; i < N_TANKS; i++) begin
      tank_x[10*i +: 10] = px[i];
      tank_y[10*i +: 10] = py[i];
    end
  end
  always_comb begin
    last = idx == IW'(N_TANKS - 1);
    ok = en_r && !wall && !oor_r && !hit;
    busy = state inside {CALC, RDA, RDB, CHECK};
    done = state == DONE;
    state_n = state == IDLE ? (frame_tick ? CALC : IDLE) : state == CALC ? RDA :
              state == RDA ? RDB : state == RDB ? CHECK :
              state == CHECK ? (last ? DONE : CALC) : IDLE;
    map_addr = state == CALC ? tile(ax, ay) : state == RDA ? tile(bx, by) : '0;
  end
  always_ff @(posedge Clk)
    state <= Reset ? IDLE : state_n;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx <= '0;
      overrun <= 1'b0;
      wall <= 1'b0;
      en_r <= 1'b0;
      oor_r <= 1'b0;
      dir_r <= '0;
      cx_r <= '0;
      cy_r <= '0;
      for (int i = 0; i < N_TANKS; i++) begin
        px[i] <= START_XY[20*i+10 +: 10];
        py[i] <= START_XY[20*i +: 10];
      end
    end else begin
      if (frame_tick && busy) overrun <= 1'b1;
      if (state == IDLE) idx <= '0;
      if (state == CALC) begin
        cx_r <= cx;
        cy_r <= cy;
        dir_r <= dir;
        en_r <= move_en[idx];
        oor_r <= oor;
      end
      if (state == RDA) wall <= |map_data;
      if (state == RDB) wall <= wall | (|map_data);
      if (state == CHECK) begin
        if (ok) begin
          px[idx] <= cx_r[9:0];
          py[idx] <= cy_r[9:0];
        end
        idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tank_motion_engine.sv
// tb_tank_motion_engine: randomized and directed checks against a per-pass arena model
module tb_tank_motion_engine;
  logic Clk = 1'b0;
  logic Reset, frame_tick;
  logic [1:0] move_en;
  logic [3:0] move_dir;
  logic [8:0] map_addr;
  logic [2:0] map_data;
  logic [19:0] tank_x, tank_y;
  logic busy, done, overrun;
  logic [2:0] map [300];
  int mx [2];
  int my [2];
  int n_cmp = 0;
  int n_err = 0;
  tank_motion_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .move_en(move_en), .move_dir(move_dir),
    .map_addr(map_addr), .map_data(map_data), .tank_x(tank_x), .tank_y(tank_y),
    .busy(busy), .done(done), .overrun(overrun)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) map_data <= map_addr < 9'd300 ? map[map_addr] : 3'd0;
  task automatic model_pass(input logic [1:0] en, input logic [3:0] dir);
    for (int i = 0; i < 2; i++) begin
      int d, nx, ny, cxp, cyp;
      bit ok, lead;
      d = int'(dir[2*i +: 2]);
      nx = mx[i];
      ny = my[i];
      case (d)
        0: ny -= 2;
        1: nx += 2;
        2: ny += 2;
        default: nx -= 2;
      endcase
      ok = en[i] && nx >= 0 && ny >= 0 && nx + 24 <= 640 && ny + 24 <= 480;
      for (int k = 0; k < 4; k++) begin
        cxp = nx + 23 * (k % 2);
        cyp = ny + 23 * (k / 2);
        lead = (d == 0 && k / 2 == 0) || (d == 2 && k / 2 == 1) || (d == 3 && k % 2 == 0) || (d == 1 && k % 2 == 1);
        if (ok && lead && map[(cyp / 32) * 20 + cxp / 32] != 3'd0) ok = 0;
      end
      for (int j = 0; j < 2; j++)
        if (j != i && mx[j] - nx < 24 && nx - mx[j] < 24 && my[j] - ny < 24 && ny - my[j] < 24) ok = 0;
      if (ok) begin
        mx[i] = nx;
        my[i] = ny;
      end
    end
  endtask
  task automatic run_pass(input logic [1:0] en, input logic [3:0] dir, input string tag);
    int cyc;
    move_en = en;
    move_dir = dir;
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    model_pass(en, dir);
    n_cmp++;
    if (cyc != 9) begin n_err++; $display("FAIL %s done_latency: got %0d want 9", tag, cyc); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (tank_x[10*i +: 10] !== 10'(mx[i]) || tank_y[10*i +: 10] !== 10'(my[i])) begin
        n_err++;
        $display("FAIL %s pos%0d: got (%0d,%0d) want (%0d,%0d)", tag, i, tank_x[10*i +: 10], tank_y[10*i +: 10], mx[i], my[i]);
      end
    end
    @(posedge Clk); #1;
  endtask
  task automatic goto_targets(input int tx0, input int ty0, input int tx1, input int ty1);
    int tx [2];
    int ty [2];
    logic [1:0] en;
    logic [3:0] dir;
    tx = '{tx0, tx1};
    ty = '{ty0, ty1};
    for (int n = 0; n < 1000 && (mx[0] != tx0 || my[0] != ty0 || mx[1] != tx1 || my[1] != ty1); n++) begin
      for (int i = 0; i < 2; i++) begin
        en[i] = mx[i] != tx[i] || my[i] != ty[i];
        dir[2*i +: 2] = mx[i] < tx[i] ? 2'd1 : mx[i] > tx[i] ? 2'd3 : my[i] < ty[i] ? 2'd2 : 2'd0;
      end
      run_pass(en, dir, "goto");
    end
    n_cmp++;
    if (tank_x !== {10'(tx1), 10'(tx0)} || tank_y !== {10'(ty1), 10'(ty0)}) begin
      n_err++;
      $display("FAIL goto_reach: got x=%h y=%h want x=%h y=%h", tank_x, tank_y, {10'(tx1), 10'(tx0)}, {10'(ty1), 10'(ty0)});
    end
  endtask
  task automatic apply_reset();
    Reset = 1'b1;
    frame_tick = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    mx = '{32, 576};
    my = '{32, 416};
  endtask
  task automatic test_reset();
    apply_reset();
    @(posedge Clk); #1;
    n_cmp++;
    if (tank_x !== {10'd576, 10'd32} || tank_y !== {10'd416, 10'd32}) begin
      n_err++; $display("FAIL reset_pos: got x=%h y=%h want x=%h y=%h", tank_x, tank_y, {10'd576, 10'd32}, {10'd416, 10'd32});
    end
    n_cmp++;
    if ({busy, done, overrun} !== 3'b000 || map_addr !== 9'd0) begin
      n_err++; $display("FAIL reset_flags: got busy/done/ovr=%b addr=%0d want 000 addr=0", {busy, done, overrun}, map_addr);
    end
  endtask
  task automatic test_single_move();
    int cyc;
    move_en = 2'b01;
    move_dir = 4'b0001;
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    n_cmp++;
    if (map_addr !== 9'd21 || busy !== 1'b1) begin n_err++; $display("FAIL addr_a: got addr=%0d busy=%b want 21 1", map_addr, busy); end
    @(posedge Clk); #1;
    n_cmp++;
    if (map_addr !== 9'd21) begin n_err++; $display("FAIL addr_b: got %0d want 21", map_addr); end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    n_cmp++;
    if (tank_x[9:0] !== 10'd32) begin n_err++; $display("FAIL pre_commit: got %0d want 32", tank_x[9:0]); end
    @(posedge Clk); #1;
    n_cmp++;
    if (tank_x[9:0] !== 10'd34) begin n_err++; $display("FAIL post_commit: got %0d want 34", tank_x[9:0]); end
    cyc = 5;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 9) begin n_err++; $display("FAIL single_latency: got %0d want 9", cyc); end
    model_pass(2'b01, 4'b0001);
    n_cmp++;
    if (tank_x !== {10'd576, 10'd34} || tank_y !== {10'd416, 10'd32}) begin
      n_err++; $display("FAIL single_pos: got x=%h y=%h want x=%h y=%h", tank_x, tank_y, {10'd576, 10'd34}, {10'd416, 10'd32});
    end
    @(posedge Clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy); end
  endtask
  task automatic test_wall();
    goto_targets(38, 32, 576, 416);
    map[22] = 3'd2;
    run_pass(2'b01, 4'b0001, "wall_pass");
    n_cmp++;
    if (tank_x[9:0] !== 10'd40) begin n_err++; $display("FAIL wall_first: got %0d want 40", tank_x[9:0]); end
    run_pass(2'b01, 4'b0001, "wall_block");
    n_cmp++;
    if (tank_x[9:0] !== 10'd40) begin n_err++; $display("FAIL wall_block: got %0d want 40", tank_x[9:0]); end
    map[22] = 3'd0;
  endtask
  task automatic test_left_edge();
    goto_targets(0, 32, 576, 416);
    run_pass(2'b01, 4'b0011, "left_edge");
    n_cmp++;
    if (tank_x[9:0] !== 10'd0 || tank_y[9:0] !== 10'd32) begin
      n_err++; $display("FAIL left_edge: got (%0d,%0d) want (0,32)", tank_x[9:0], tank_y[9:0]);
    end
  endtask
  task automatic test_contention();
    goto_targets(100, 100, 126, 100);
    run_pass(2'b11, 4'b1101, "contention");
    n_cmp++;
    if (tank_x !== {10'd126, 10'd102}) begin n_err++; $display("FAIL contention: got x=%h want x=%h", tank_x, {10'd126, 10'd102}); end
  endtask
  task automatic test_random();
    for (int k = 0; k < 300; k++) map[k] = $urandom_range(0, 9) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
    for (int n = 0; n < 80; n++) run_pass(2'($urandom), 4'($urandom), "random");
    for (int k = 0; k < 300; k++) map[k] = 3'd0;
  endtask
  task automatic test_overrun();
    logic [3:0] dir;
    int cyc;
    dir = 4'($urandom);
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    move_en = 2'b11;
    move_dir = dir;
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    cyc = 4;
    n_cmp++;
    if (overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", overrun); end
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge Clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 9) begin n_err++; $display("FAIL overrun_latency: got %0d want 9", cyc); end
    model_pass(2'b11, dir);
    n_cmp++;
    if (tank_x !== {10'(mx[1]), 10'(mx[0])} || tank_y !== {10'(my[1]), 10'(my[0])}) begin
      n_err++; $display("FAIL overrun_pos: got x=%h y=%h want x=%h y=%h", tank_x, tank_y, {10'(mx[1]), 10'(mx[0])}, {10'(my[1]), 10'(my[0])});
    end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin n_err++; $display("FAIL overrun_ignored: got busy=%b ovr=%b want 0 1", busy, overrun); end
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    repeat (5) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    n_cmp++;
    if (tank_x !== {10'd576, 10'd32} || tank_y !== {10'd416, 10'd32} || {busy, done, overrun} !== 3'b000 || map_addr !== 9'd0) begin
      n_err++; $display("FAIL mid_reset: got x=%h y=%h flags=%b addr=%0d want reset values", tank_x, tank_y, {busy, done, overrun}, map_addr);
    end
    Reset = 1'b0;
    mx = '{32, 576};
    my = '{32, 416};
    @(posedge Clk); #1;
  endtask
  task automatic test_far_edges();
    goto_targets(32, 0, 616, 456);
    run_pass(2'b11, 4'b0100, "top_right");
    n_cmp++;
    if (tank_y[9:0] !== 10'd0 || tank_x[19:10] !== 10'd616) begin
      n_err++; $display("FAIL top_right: got y0=%0d x1=%0d want 0 616", tank_y[9:0], tank_x[19:10]);
    end
    run_pass(2'b10, 4'b1000, "bottom");
    n_cmp++;
    if (tank_y[19:10] !== 10'd456) begin n_err++; $display("FAIL bottom: got %0d want 456", tank_y[19:10]); end
  endtask
  initial begin
    Reset = 1'b1;
    frame_tick = 1'b0;
    move_en = '0;
    move_dir = '0;
    for (int k = 0; k < 300; k++) map[k] = 3'd0;
    test_reset();
    test_single_move();
    test_wall();
    test_left_edge();
    test_contention();
    test_random();
    test_overrun();
    test_far_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
